// File: rtl/sub_16bit_iterative_pkg.sv
// sub_16bit_iterative_pkg: shared state encoding and sizing for the iterative subtractor
package sub_16bit_iterative_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
  localparam int WIDTH = 16;
  localparam int NIBBLES = 4;
  localparam int SLICE_W = 4;
  localparam logic [1:0] LAST_K = 2'(NIBBLES - 1);
endpackage

// File: rtl/sub_16bit_iterative_cla_4bit_slice.sv
// cla_4bit_slice: combinational 4-bit carry-lookahead adder slice
//   a, b : 4-bit addends   cin : carry-in
//   s    : 4-bit sum       cout: carry-out
module cla_4bit_slice
  import sub_16bit_iterative_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout
);
  logic [SLICE_W-1:0] g, p;
  logic [SLICE_W:0] c;
  always_comb begin
    g = a & b;
    p = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    s = p ^ c[SLICE_W-1:0];
    cout = c[SLICE_W];
  end
endmodule

// File: rtl/sub_16bit_iterative.sv
// sub_16bit_iterative: in1 - in2 - b_in computed one 4-bit CLA slice per clock
//   clk, rst (async, active-high), start : control
//   in1, in2, b_in                        : operands, latched when start is accepted in IDLE
//   diff, b_out, overflow                 : registered result, held until the next accepted start
//   busy (CALC), done (one-cycle pulse)   : handshake
module sub_16bit_iterative
  import sub_16bit_iterative_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             b_in,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             overflow,
  output logic             busy,
  output logic             done
);
  state_t state_q, state_d;
  logic [1:0] k_q, k_d;
  logic c_q, c_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic b_out_q, b_out_d, ovf_q, ovf_d, busy_q, busy_d, done_q, done_d;
  logic [SLICE_W-1:0] s;
  logic cout;

  cla_4bit_slice u_slice (
    .a   (a_q[{k_q, 2'b00} +: SLICE_W]),
    .b   (b_q[{k_q, 2'b00} +: SLICE_W]),
    .cin (c_q),
    .s   (s),
    .cout(cout)
  );

  // b_q holds ~in2, so in2[15] differs from in1[15] exactly when b_q[15] equals a_q[15].
  // Flags are resolved on the final slice so they are valid on entry to DONE.
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    c_d = c_q;
    a_d = a_q;
    b_d = b_q;
    diff_d = diff_q;
    b_out_d = b_out_q;
    ovf_d = ovf_q;
    if (state_q == IDLE && start) begin
      a_d = in1;
      b_d = ~in2;
      c_d = ~b_in;
      diff_d = '0;
      b_out_d = 1'b0;
      ovf_d = 1'b0;
      k_d = 2'd0;
      state_d = CALC;
    end else if (state_q == CALC) begin
      diff_d[{k_q, 2'b00} +: SLICE_W] = s;
      c_d = cout;
      k_d = k_q + 2'd1;
      if (k_q == LAST_K) begin
        state_d = DONE;
        b_out_d = ~cout;
        ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) & (s[SLICE_W-1] != a_q[WIDTH-1]);
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
    busy_d = state_d == CALC;
    done_d = state_d == DONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q <= 2'd0;
      c_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      diff_q <= '0;
      b_out_q <= 1'b0;
      ovf_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      c_q <= c_d;
      a_q <= a_d;
      b_q <= b_d;
      diff_q <= diff_d;
      b_out_q <= b_out_d;
      ovf_q <= ovf_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign diff = diff_q;
  assign b_out = b_out_q;
  assign overflow = ovf_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_sub_16bit_iterative.sv
// tb_sub_16bit_iterative: directed self-checking bench for the iterative subtractor
module tb_sub_16bit_iterative;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, b_in = 1'b0;
  logic [15:0] in1 = '0, in2 = '0;
  logic [15:0] diff;
  logic b_out, overflow, busy, done;
  int checks = 0, failures = 0;

  sub_16bit_iterative dut (
    .clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2), .b_in(b_in),
    .diff(diff), .b_out(b_out), .overflow(overflow), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic bi,
                    input logic [15:0] ed, input logic eb, input logic eo);
    @(negedge clk);
    in1 = a; in2 = b; b_in = bi; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    in1 = ~a; in2 = ~b; b_in = ~bi;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_nodone"}, 32'(done), 32'd0);
    end
    @(negedge clk);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_diff"}, 32'(diff), 32'(ed));
    chk({tag, "_bout"}, 32'(b_out), 32'(eb));
    chk({tag, "_ovf"}, 32'(overflow), 32'(eo));
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int d1, d2, nd;
    #1;
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_flags", {29'd0, b_out, overflow, busy}, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    op("basic", 16'd16785, 16'd3245, 1'b0, 16'd13540, 1'b0, 1'b0);
    op("neg", 16'd3245, 16'd16785, 1'b0, 16'hCB1C, 1'b1, 1'b0);
    op("bchain0", 16'd0, 16'd0, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    op("bchain1", 16'd16785, 16'd3245, 1'b1, 16'd13539, 1'b0, 1'b0);
    op("ovf_neg", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    op("ovf_pos", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);

    repeat (5) @(negedge clk);
    chk("hold_diff", 32'(diff), 32'h8000);
    chk("hold_flags", {30'd0, b_out, overflow}, 32'd3);

    @(negedge clk);
    in1 = 16'd1000; in2 = 16'd1; b_in = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    in1 = 16'd5; in2 = 16'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("ign_done", 32'(done), 32'd1);
    chk("ign_diff", 32'(diff), 32'd999);
    @(negedge clk);
    chk("ign_noreaccept", 32'(busy), 32'd0);

    @(negedge clk);
    in1 = 16'd10; in2 = 16'd3; start = 1'b1;
    d1 = -1; d2 = -1; nd = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (d1 < 0) d1 = i; else if (d2 < 0) d2 = i;
      end
    end
    start = 1'b0;
    chk("cont_npulses", 32'(nd >= 2), 32'd1);
    chk("cont_period", 32'(d2 - d1), 32'd6);
    chk("cont_diff", 32'(diff), 32'd7);
    repeat (7) @(negedge clk);

    in1 = 16'd100; in2 = 16'd1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_outs", {13'd0, diff, b_out, overflow, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("mrst_nodone", 32'(nd), 32'd0);
    op("post_rst", 16'd25000, 16'd40535, 1'b0, 16'd50001, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
